load_store_unit: RTL

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

---
 rtl/lsu_pkg.sv | 36 +++
 rtl/load_align.sv | 27 ++
 rtl/load_store_unit.sv | 134 +++++++++++++
 3 files changed

// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: funct3 codes, access sizes,
// FSM state encoding and the sub-word lane-merge helper.
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'd0;
  localparam logic [2:0] F3_H  = 3'd1;
  localparam logic [2:0] F3_W  = 3'd2;
  localparam logic [2:0] F3_BU = 3'd4;
  localparam logic [2:0] F3_HU = 3'd5;

  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;

  typedef enum logic {
    IDLE   = 1'b0,
    RMW_WR = 1'b1
  } lsu_state_e;

  // Replace one byte or halfword lane of a memory word with store data.
  function automatic logic [31:0] merge_lane(input logic [31:0] word,
                                             input logic [31:0] data,
                                             input logic [1:0]  offset,
                                             input logic        is_half);
    logic [31:0] res;
    res = word;
    if (is_half) begin
      if (offset[1]) res[31:16] = data[15:0];
      else           res[15:0]  = data[15:0];
    end else begin
      res[{offset, 3'b000} +: 8] = data[7:0];
    end
    return res;
  endfunction

endpackage

// File: rtl/load_align.sv
// Load lane selection and sign/zero extension of a fetched memory word.
module load_align
  import lsu_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  offset,
  input  logic [2:0]  funct3,
  output logic [31:0] data
);

  logic [7:0]  lane_b;
  logic [15:0] lane_h;

  always_comb begin
    lane_b = word[{offset, 3'b000} +: 8];
    lane_h = offset[1] ? word[31:16] : word[15:0];
    case (funct3)
      F3_B:    data = {{24{lane_b[7]}}, lane_b};
      F3_BU:   data = {24'h000000, lane_b};
      F3_H:    data = {{16{lane_h[15]}}, lane_h};
      F3_HU:   data = {16'h0000, lane_h};
      F3_W:    data = word;
      default: data = '0;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// RV32I load/store unit: 0-cycle loads, 1-cycle SW, 2-cycle RMW for SB/SH.
// Optional macro LSU_MISALIGN_TRAP_EN: flag and suppress misaligned accesses.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int unsigned ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  input  logic              req_load,
  input  logic [2:0]        funct3,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       store_data,
  output logic [31:0]       load_data,
  output logic              stall,
  output logic              misaligned,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wd,
  output logic              mem_read,
  output logic              mem_write,
  input  logic [31:0]       mem_rd
);

  lsu_state_e        state, state_nxt;
  logic [ADDR_W-1:0] rmw_addr;
  logic [31:0]       rmw_word;
  logic [1:0]        size;
  logic [1:0]        offset;
  logic [ADDR_W-1:0] addr_aligned;
  logic [31:0]       aligned_data;
  logic              legal;
  logic              trap_hit;
  logic              active;
  logic              sub_store;

  assign size         = funct3[1:0];
  assign addr_aligned = {addr[ADDR_W-1:2], 2'b00};

  always_comb begin
    if (req_load)
      legal = (funct3 == F3_B) || (funct3 == F3_H) || (funct3 == F3_W) ||
              (funct3 == F3_BU) || (funct3 == F3_HU);
    else
      legal = (funct3 == F3_B) || (funct3 == F3_H) || (funct3 == F3_W);
  end

  // Halfword/word offsets snap to natural alignment, which is what an
  // untrapped misaligned access uses and is exact for aligned ones.
  always_comb begin
    case (size)
      SZ_B:    offset = addr[1:0];
      SZ_H:    offset = {addr[1], 1'b0};
      default: offset = 2'b00;
    endcase
  end

`ifdef LSU_MISALIGN_TRAP_EN
  logic mis_raw;
  assign mis_raw    = ((size == SZ_H) && addr[0]) ||
                      ((size == SZ_W) && (addr[1:0] != 2'b00));
  assign trap_hit   = mis_raw;
  assign misaligned = rst_n && (state == IDLE) && req_valid && legal && mis_raw;
`else
  assign trap_hit   = 1'b0;
  assign misaligned = 1'b0;
`endif

  assign active    = rst_n && (state == IDLE) && req_valid && legal && !trap_hit;
  assign sub_store = active && !req_load && (size != SZ_W);

  load_align u_load_align (
    .word   (mem_rd),
    .offset (offset),
    .funct3 (funct3),
    .data   (aligned_data)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      rmw_addr <= '0;
      rmw_word <= '0;
    end else begin
      state <= state_nxt;
      if (sub_store) begin
        rmw_addr <= addr_aligned;
        rmw_word <= merge_lane(mem_rd, store_data, offset, size == SZ_H);
      end
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (sub_store) state_nxt = RMW_WR;
      RMW_WR:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    load_data = '0;
    stall     = 1'b0;
    mem_addr  = '0;
    mem_wd    = '0;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    case (state)
      IDLE: begin
        if (active) begin
          mem_addr = addr_aligned;
          if (req_load) begin
            mem_read  = 1'b1;
            load_data = aligned_data;
          end else if (size == SZ_W) begin
            mem_write = 1'b1;
            mem_wd    = store_data;
          end else begin
            mem_read = 1'b1;
            stall    = 1'b1;
          end
        end
      end
      RMW_WR: begin
        mem_write = 1'b1;
        mem_addr  = rmw_addr;
        mem_wd    = rmw_word;
      end
      default: ;
    endcase
  end

endmodule
